// File: rtl/led_pkg.sv
// led_pkg: shared types and constants for the LED scan scheduler.
// Holds the FSM state type, default geometry and on-time helper.
package led_pkg;

  localparam int LINE_BITS_DEF  = 5;
  localparam int PLANE_BITS_DEF = 3;
  localparam int TIMER_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_BLANK,
    S_LATCH,
    S_DISPLAY
  } state_t;

  // Binary-weighted on-time: base scaled by 2^plane.
  function automatic logic [TIMER_W-1:0] on_time(
    input logic [TIMER_W-1:0] base,
    input logic [3:0]         plane
  );
    return base << plane;
  endfunction

endpackage

// File: rtl/led_scan_scheduler_if.sv
// Row request handshake between scheduler and pixel shifter.
// master: shift_req/shift_line/shift_plane out, shift_done in.
interface led_scan_scheduler_if #(
  parameter int LINE_BITS  = 5,
  parameter int PLANE_BITS = 3
) ();

  logic                  shift_req;
  logic [LINE_BITS-1:0]  shift_line;
  logic [PLANE_BITS-1:0] shift_plane;
  logic                  shift_done;

  modport master (
    output shift_req,
    output shift_line,
    output shift_plane,
    input  shift_done
  );

  modport slave (
    input  shift_req,
    input  shift_line,
    input  shift_plane,
    output shift_done
  );

endinterface

// File: rtl/oe_timer.sv
// oe_timer: loadable down-counter that stops at zero.
// Ports: clk, reset_n, load, load_val in; count, zero out.
module oe_timer
  import led_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] load_val,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler: bit-plane scan sequencer for a HUB75-style panel.
// Ports: clk, reset_n, enable; shf (row handshake); line_select, stb, oe, frame_done, busy.
module led_scan_scheduler
  import led_pkg::*;
#(
  parameter int LINE_BITS      = LINE_BITS_DEF,
  parameter int PLANE_BITS     = PLANE_BITS_DEF,
  parameter int BASE_OE_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  led_scan_scheduler_if.master shf,
  output logic [LINE_BITS-1:0] line_select,
  output logic                 stb,
  output logic                 oe,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int ROW_BITS = LINE_BITS + PLANE_BITS;

  localparam logic [TIMER_W-1:0] BASE =
    TIMER_W'(BASE_OE_CYCLES);

  localparam logic [ROW_BITS-1:0] ROW_LAST = '1;

  state_t state;

  // row_q: row most recently requested, i.e. the one
  // sitting in the shifter. disp_q: row on the panel.
  // Both are {line, plane}, so a plain increment walks
  // planes fastest and carries into the line.
  logic [ROW_BITS-1:0] row_q;
  logic [ROW_BITS-1:0] disp_q;
  logic [ROW_BITS-1:0] row_nxt;

  logic pending;
  logic stopping;

  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_val;
  logic [TIMER_W-1:0] tmr_cnt;
  logic               tmr_zero;

  logic shift_clear;

  assign row_nxt  = row_q + 1'b1;
  assign tmr_load = (state == S_LATCH);
  assign tmr_val  = on_time(BASE, 4'(row_q[PLANE_BITS-1:0]));

  // A done arriving in the same cycle counts as received.
  assign shift_clear = !pending || shf.shift_done;

  oe_timer u_oe_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .count    (tmr_cnt),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= S_IDLE;
      row_q           <= '0;
      disp_q          <= '0;
      pending         <= 1'b0;
      stopping        <= 1'b0;
      shf.shift_req   <= 1'b0;
      shf.shift_line  <= '0;
      shf.shift_plane <= '0;
      line_select     <= '0;
      stb             <= 1'b0;
      oe              <= 1'b1;
      frame_done      <= 1'b0;
      busy            <= 1'b0;
    end else begin
      shf.shift_req <= 1'b0;
      stb           <= 1'b0;
      frame_done    <= 1'b0;

      unique case (state)
        S_IDLE: begin
          oe <= 1'b1;
          if (enable) begin
            state           <= S_FILL;
            busy            <= 1'b1;
            row_q           <= '0;
            shf.shift_req   <= 1'b1;
            shf.shift_line  <= '0;
            shf.shift_plane <= '0;
          end
        end

        S_FILL: begin
          if (shf.shift_done) begin
            state       <= S_BLANK;
            disp_q      <= row_q;
            line_select <= row_q[ROW_BITS-1:PLANE_BITS];
          end
        end

        S_BLANK: begin
          state <= S_LATCH;
          stb   <= 1'b1;
        end

        // Prefetch of the next row overlaps with on-time.
        S_LATCH: begin
          state    <= S_DISPLAY;
          oe       <= 1'b0;
          stopping <= !enable;
          if (enable) begin
            shf.shift_req <= 1'b1;
            {shf.shift_line, shf.shift_plane} <= row_nxt;
            row_q   <= row_nxt;
            pending <= 1'b1;
          end
        end

        S_DISPLAY: begin
          // Blank on the last counted cycle so on-time is
          // exactly the loaded count.
          if (tmr_cnt <= TIMER_W'(1)) begin
            oe <= 1'b1;
          end
          if (shf.shift_done) begin
            pending <= 1'b0;
          end
          if (tmr_zero && shift_clear) begin
            pending    <= 1'b0;
            frame_done <= (disp_q == ROW_LAST);
            if (stopping) begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              stopping <= 1'b0;
              row_q    <= '0;
              disp_q   <= '0;
            end else begin
              state       <= S_BLANK;
              disp_q      <= row_q;
              line_select <= row_q[ROW_BITS-1:PLANE_BITS];
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          oe    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Bench for led_scan_scheduler: random shifter latencies and
// enable/reset events checked against an event-level scan model.
module tb_led_scan_scheduler;

  localparam int LB   = 5;
  localparam int PB   = 3;
  localparam int BASE = 8;
  localparam int NPL  = 1 << PB;
  localparam int NROW = (1 << LB) * NPL;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic [LB-1:0] line_select;
  logic          stb;
  logic          oe;
  logic          frame_done;
  logic          busy;

  led_scan_scheduler_if #(.LINE_BITS(LB), .PLANE_BITS(PB)) shf ();

  led_scan_scheduler #(
    .LINE_BITS      (LB),
    .PLANE_BITS     (PB),
    .BASE_OE_CYCLES (BASE)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .shf         (shf.master),
    .line_select (line_select),
    .stb         (stb),
    .oe          (oe),
    .frame_done  (frame_done),
    .busy        (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int on_cycles(input int row);
    return BASE << (row % NPL);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // scan model state
  int exp_row, req_row, shifted_row, run_row;
  int f_exp, rise_c, done_c, fall_c, fd_exp, idle_exp, done_due;
  int stb_cnt;
  int fd_seen = 0;
  int fd_want = 0;
  int falls = 0;
  bit p_oe, p_stb, m_idle, fill, stop_run, idle_prev;
  int m_d, m_n, m_r, m_dly;
  bit force_done;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_row = 0; req_row = 0; shifted_row = 0; run_row = 0;
      f_exp = -1; rise_c = -1; done_c = -1; fall_c = 0;
      fd_exp = -1; idle_exp = -1; done_due = -1; stb_cnt = 0;
      p_oe = 1'b1; p_stb = 1'b0; m_idle = 1'b1;
      fill = 1'b0; stop_run = 1'b0;
    end else begin
      idle_prev = m_idle;
      if (idle_prev)
        chk("start_req", int'(shf.shift_req), int'(enable));

      if (!oe && p_oe) begin
        falls++;
        chk("fall_cycle", cyc, f_exp);
        chk("line_select", int'(line_select), shifted_row / NPL);
        chk("stb_pulses", stb_cnt, 1);
        chk("stb_before_on", int'(p_stb), 1);
        chk("req_at_fall", int'(shf.shift_req), int'(enable));
        run_row  = shifted_row;
        fall_c   = cyc;
        stb_cnt  = 0;
        stop_run = !enable;
        fill     = 1'b0;
        rise_c   = -1;
        f_exp    = -1;
      end

      if (stb) stb_cnt++;

      if (oe && !p_oe) begin
        chk("on_time", cyc - fall_c, on_cycles(run_row));
        rise_c = cyc;
        if (stop_run) begin
          idle_exp = cyc + 1;
          if (run_row == NROW - 1) begin
            fd_exp = cyc + 1;
            fd_want++;
          end
        end
      end

      if (cyc == idle_exp) begin
        chk("idle_busy", int'(busy), 0);
        m_idle  = 1'b1;
        exp_row = 0;
      end

      if (shf.shift_req) begin
        if (idle_prev) begin
          fill     = 1'b1;
          stop_run = 1'b0;
          m_idle   = 1'b0;
        end
        chk("req_row",
            int'(shf.shift_line) * NPL + int'(shf.shift_plane),
            exp_row);
        req_row = exp_row;
        exp_row = (exp_row + 1) % NROW;
        if (fill) begin
          m_dly = int'($urandom_range(1, 6));
        end else begin
          m_n = on_cycles(run_row);
          m_r = int'($urandom_range(0, 9));
          if (m_r < 6)      m_dly = int'($urandom_range(1, 6));
          else if (m_r < 8) m_dly = m_n;
          else if (m_r < 9) m_dly = m_n + int'($urandom_range(1, 20));
          else              m_dly = 50;
        end
        done_due = cyc + m_dly;
        done_c   = done_due;
        if (fill) rise_c = cyc;
      end

      if (f_exp < 0 && rise_c >= 0 && done_c >= 0 && !stop_run) begin
        m_d   = (rise_c > done_c) ? rise_c : done_c;
        f_exp = m_d + 3;
        if (!fill && run_row == NROW - 1) begin
          fd_exp = m_d + 1;
          fd_want++;
        end
        shifted_row = req_row;
        rise_c = -1;
        done_c = -1;
      end

      if (frame_done) begin
        fd_seen++;
        chk("frame_done_cycle", cyc, fd_exp);
        fd_exp = -1;
      end

      p_oe  = oe;
      p_stb = stb;
    end
  end

  // shifter responder
  initial begin
    shf.shift_done = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      shf.shift_done = (cyc == done_due) || force_done;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time %0t limit reached", $time);
    $fatal(1, "watchdog");
  end

  int n;
  int k;

  initial begin
    reset_n    = 1'b1;
    enable     = 1'b0;
    force_done = 1'b0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_oe", int'(oe), 1);
    chk("rst_stb", int'(stb), 0);
    chk("rst_req", int'(shf.shift_req), 0);
    chk("rst_fd", int'(frame_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_line_sel", int'(line_select), 0);
    chk("rst_shift_line", int'(shf.shift_line), 0);
    chk("rst_shift_plane", int'(shf.shift_plane), 0);

    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #2 enable = 1'b1;

    // full frame, then into line 2 of the next one
    n = 0;
    while (!(fd_seen >= 1 && run_row == 19 && !oe) && n < 90000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("frame_timeout", int'(n < 90000), 1);
    enable = 1'b0;

    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("stop_timeout", int'(n < 3000), 1);
    chk("stop_oe", int'(oe), 1);
    chk("stop_stb", int'(stb), 0);
    chk("stop_line_sel", int'(line_select), 2);

    repeat (5) @(negedge clk);
    #2 enable = 1'b1;
    k = falls;
    n = 0;
    while (!(falls >= k + 3 && !oe) && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("restart_timeout", int'(n < 3000), 1);
    chk("pre_reset_oe", int'(oe), 0);

    // asynchronous reset in the middle of on-time
    #1 reset_n = 1'b0;
    #1;
    chk("arst_oe", int'(oe), 1);
    chk("arst_stb", int'(stb), 0);
    chk("arst_req", int'(shf.shift_req), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_line_sel", int'(line_select), 0);
    chk("arst_shift_line", int'(shf.shift_line), 0);
    chk("arst_shift_plane", int'(shf.shift_plane), 0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    #2 force_done = 1'b1;
    @(negedge clk);
    #2 force_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      #2;
      chk("post_rst_busy", int'(busy), 0);
      chk("post_rst_oe", int'(oe), 1);
    end

    // short run from a clean start
    enable = 1'b1;
    k = falls;
    n = 0;
    while (falls < k + 6 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("short_timeout", int'(n < 3000), 1);
    enable = 1'b0;
    n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("short_stop_timeout", int'(n < 3000), 1);
    repeat (3) @(negedge clk);

    chk("fd_count", fd_seen, fd_want);
    chk("frames", fd_seen, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_scan_scheduler.md
LED_SCAN_SCHEDULER -- requirements
Module: led_scan_scheduler

Interface
REQ-001 Parameter LINE_BITS, default 5: width of line address (2^LINE_BITS scan lines).
REQ-002 Parameter PLANE_BITS, default 3: width of bit-plane index (2^PLANE_BITS planes).
REQ-003 Parameter BASE_OE_CYCLES, default 8, range 1..255: plane-0 on-time in clk cycles.
REQ-004 clk  in  1  system clock; one clock domain, all logic on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 enable  in  1  level; 1 = keep scanning, 0 = stop at next display boundary.
REQ-007 shift_req  out  1  one-cycle pulse: pixel shifter loads row shift_line/shift_plane.
REQ-008 shift_line  out  LINE_BITS  line index of the requested row, stable until next shift_req.
REQ-009 shift_plane  out  PLANE_BITS  plane index of the requested row, stable until next shift_req.
REQ-010 shift_done  in  1  one-cycle pulse from shifter: requested row fully shifted.
REQ-011 line_select  out  LINE_BITS  panel row address.
REQ-012 stb  out  1  panel latch strobe, active-high.
REQ-013 oe  out  1  panel output enable, active-low (1 = blanked).
REQ-014 frame_done  out  1  one-cycle pulse at end of last line/last plane display.
REQ-015 busy  out  1  1 in every state except IDLE.

Function
REQ-016 States: IDLE, FILL, BLANK, LATCH, DISPLAY; all outputs registered.
REQ-017 IDLE: oe=1, stb=0; enable=1 -> next cycle shift_req=1 for (line 0, plane 0), state FILL.
REQ-018 FILL: oe=1; on shift_done -> BLANK next cycle.
REQ-019 BLANK: oe=1 for exactly one cycle; line_select loaded with displayed-row line; -> LATCH.
REQ-020 LATCH: stb=1 for exactly one cycle, oe=1; -> DISPLAY.
REQ-021 DISPLAY entry: timer loaded with BASE_OE_CYCLES << plane (16-bit, no overflow); oe=0 while timer>0.
REQ-022 DISPLAY entry with enable=1: shift_req pulse for next (line, plane) same cycle as oe first goes 0; pending flag set.
REQ-023 Scan order: plane increments fastest; plane wraps max->0 with line+1; line wraps max->0.
REQ-024 shift_done in DISPLAY clears pending; shift_done in IDLE/BLANK/LATCH ignored.
REQ-025 Timer reaching 0: oe=1 that cycle onward; exit when timer=0 and pending=0 -> BLANK.
REQ-026 shift_done same cycle timer reaches 0: both honoured, BLANK next cycle.
REQ-027 shift_done arriving late: remain DISPLAY with oe=1 (no extra on-time).
REQ-028 enable=0 sampled at DISPLAY entry: no shift_req; at timer=0 -> IDLE, line/plane counters cleared.
REQ-029 frame_done pulses on the DISPLAY exit of (line max, plane max).
REQ-030 Displayed plane p gets exactly BASE_OE_CYCLES*2^p cycles of oe=0 per visit.

Reset
REQ-031 Asserted reset_n immediately forces IDLE, oe=1, stb=0, shift_req=0, frame_done=0, busy=0, line_select=0, shift_line=0, shift_plane=0, counters and pending cleared.
REQ-032 Reset mid-DISPLAY blanks panel asynchronously; outstanding shift_done after release ignored (IDLE).

Structure
REQ-033 Shared package led_pkg holds state enum, LINE_BITS/PLANE_BITS defaults, timer width constant (16).
REQ-034 One sub-module oe_timer: loadable 16-bit down-counter with zero flag.

Verification
REQ-035 enable=1, shift_done 3 cycles after each shift_req -> first oe=0 run 8 cycles (plane 0), then 16, 32 ... 1024 for plane 7.
REQ-036 Full frame with defaults -> 256 rows displayed, line_select 0..31 each held 8 planes, one frame_done pulse, scan restarts at line 0 plane 0.
REQ-037 shift_done delayed 50 cycles during plane 0 DISPLAY -> oe=0 for 8 cycles then oe=1 until BLANK, stb single cycle after.
REQ-038 enable dropped during line 2 plane 4 -> no further shift_req, oe=0 exactly 128 cycles, then IDLE, busy=0, next start at line 0 plane 0.
REQ-039 reset_n low mid-DISPLAY -> oe=1 same cycle without clk edge, all outputs at reset values; shift_done after release causes no transition.
REQ-040 shift_done coincident with timer zero -> BLANK on next cycle, no stall cycle.
